// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: one-hot FSM states and requester IDs.
package mem_arb_pkg;
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_WAIT  = 4'b0100,
    S_RESP  = 4'b1000
  } state_t;

  localparam logic [2:0] REQ_NONE = 3'b000;
  localparam logic [2:0] REQ_DM   = 3'b001;
  localparam logic [2:0] REQ_IF   = 3'b010;
  localparam logic [2:0] REQ_DBG  = 3'b100;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker: fixed DM > IF > DBG priority, with a starvation
// override that hands the grant to DBG.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_dm_req,
  input  logic       i_if_req,
  input  logic       i_dbg_req,
  input  logic       i_starve_hit,
  output logic [2:0] o_grant
);
  always_comb begin
    o_grant = REQ_NONE;
    if (i_dbg_req && i_starve_hit) o_grant = REQ_DBG;
    else if (i_dm_req)             o_grant = REQ_DM;
    else if (i_if_req)             o_grant = REQ_IF;
    else if (i_dbg_req)            o_grant = REQ_DBG;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for DM, IF and DBG requesters. One access at a
// time; all outputs are registered off the next state.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic              o_dm_ack,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic              o_dbg_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

  state_t            r_state, w_next;
  logic [2:0]        r_win, w_grant;
  logic              r_we, w_any, w_starve_hit;
  logic [3:0]        r_lat, r_starve;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_starve_hit = (r_starve == STARVE_TOP);
  assign w_any        = |w_grant;

  mem_arb_pick u_pick (
    .i_dm_req     (i_dm_req),
    .i_if_req     (i_if_req),
    .i_dbg_req    (i_dbg_req),
    .i_starve_hit (w_starve_hit),
    .o_grant      (w_grant)
  );

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    case (w_grant)
      REQ_DM:  begin w_sel_we = i_dm_we;  w_sel_addr = i_dm_addr;  w_sel_wdata = i_dm_wdata;  end
      REQ_IF:  w_sel_addr = i_if_addr;
      REQ_DBG: begin w_sel_we = i_dbg_we; w_sel_addr = i_dbg_addr; w_sel_wdata = i_dbg_wdata; end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: w_next = r_we ? S_RESP : S_WAIT;
      S_WAIT:  if (r_lat == '0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win       <= REQ_NONE;
      r_we        <= 1'b0;
      r_lat       <= '0;
      r_starve    <= '0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_rdata     <= '0;
      o_busy      <= 1'b0;
      o_dm_ack    <= 1'b0;
      o_if_ack    <= 1'b0;
      o_dbg_ack   <= 1'b0;
    end else begin
      // Request fields are captured once at arbitration and held for the access.
      if (r_state == S_IDLE) begin
        if (w_any) begin
          r_win       <= w_grant;
          r_we        <= w_sel_we;
          o_mem_addr  <= w_sel_addr;
          o_mem_wdata <= w_sel_wdata;
        end
        if (!i_dbg_req || w_grant == REQ_DBG) r_starve <= '0;
        else if (w_any && !w_starve_hit)      r_starve <= r_starve + 4'd1;
      end
      if (r_state == S_ISSUE)                 r_lat <= LAT_LOAD;
      else if (r_state == S_WAIT && r_lat != '0) r_lat <= r_lat - 4'd1;
      if (r_state == S_WAIT && r_lat == '0)   o_rdata <= i_mem_rdata;
      o_mem_en <= (w_next == S_ISSUE);
      o_mem_we <= (w_next == S_ISSUE) && w_sel_we;
      o_busy   <= (w_next != S_IDLE);
      {o_dbg_ack, o_if_ack, o_dm_ack} <= (w_next == S_RESP) ? r_win : REQ_NONE;
    end
  end
endmodule
